// File: rtl/hc595_rx.sv
// Receive side of the 74HC595 serial display link: oversamples ds/shcp/stcp/oe in
// sys_clk, rebuilds the latched sel/seg frame and reports frame integrity.
module hc595_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 14
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ds,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        oe,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        disp_en,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] ds_p0, sh_p0, st_p0, oe_p0;
  logic                   ds_s, sh_s, st_s, oe_s;
  logic                   live, sh_arm, st_arm, sh_prev, st_prev;
  logic                   sh_rise, st_rise;
  logic [FRAME_BITS-1:0]  sr;
  logic [CNT_W-1:0]       bit_cnt;

  // stage p0: parallel synchronizers; ds shares its tap with shcp to keep alignment
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ds_p0 <= '0;
      sh_p0 <= '0;
      st_p0 <= '0;
      oe_p0 <= '0;
    end else begin
      ds_p0 <= {ds_p0[SYNC_STAGES-2:0], ds};
      sh_p0 <= {sh_p0[SYNC_STAGES-2:0], shcp};
      st_p0 <= {st_p0[SYNC_STAGES-2:0], stcp};
      oe_p0 <= {oe_p0[SYNC_STAGES-2:0], oe};
    end
  end

  assign ds_s = ds_p0[SYNC_STAGES-1];
  assign sh_s = sh_p0[SYNC_STAGES-1];
  assign st_s = st_p0[SYNC_STAGES-1];
  assign oe_s = oe_p0[SYNC_STAGES-1];

  // A clock line must be seen low after reset before its rising edge counts, so a
  // line already high at release is ignored; live marks the first real pin sample.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      live    <= 1'b0;
      sh_arm  <= 1'b0;
      st_arm  <= 1'b0;
      sh_prev <= 1'b0;
      st_prev <= 1'b0;
    end else begin
      live    <= 1'b1;
      sh_arm  <= sh_arm | (live & ~sh_p0[0]);
      st_arm  <= st_arm | (live & ~st_p0[0]);
      sh_prev <= sh_s;
      st_prev <= st_s;
    end
  end

  assign sh_rise = sh_s & ~sh_prev & sh_arm;
  assign st_rise = st_s & ~st_prev & st_arm;

  // stage p1: shift register, bit counter, latch and integrity pulses
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sr          <= '0;
      bit_cnt     <= '0;
      sel         <= '0;
      seg         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      disp_en     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      disp_en     <= ~oe_s;
      if (sh_rise)
        sr <= {sr[FRAME_BITS-2:0], ds_s};
      if (st_rise) begin
        // latch sees sr before any same-cycle shift, like the real 595
        for (int i = 0; i < 6; i++)
          sel[i] <= sr[FRAME_BITS-1-i];
        seg     <= sr[7:0];
        bit_cnt <= sh_rise ? CNT_W'(1) : '0;
        if (bit_cnt == CNT_FULL) begin
          frame_valid <= 1'b1;
          frame_cnt   <= frame_cnt + 16'd1;
        end else begin
          frame_err <= 1'b1;
        end
      end else if (sh_rise) begin
        bit_cnt <= sat_inc(bit_cnt);
      end
    end
  end

endmodule

// File: tb/tb_hc595_rx.sv
// Randomized bench for hc595_rx: a bit-history model predicts every latched frame.
module tb_hc595_rx;
  logic        sys_clk = 1'b0;
  logic        sys_rst, ds, shcp, stcp, oe;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        disp_en, frame_valid, frame_err;
  logic [15:0] frame_cnt;

  hc595_rx #(.SYNC_STAGES(2), .FRAME_BITS(14)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ds(ds), .shcp(shcp), .stcp(stcp),
    .oe(oe), .sel(sel), .seg(seg), .disp_en(disp_en), .frame_valid(frame_valid),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  // model: every bit shifted since reset (seeded with 14 zeros), bits since last latch
  logic        hist[$];
  int          since;
  logic [15:0] exp_cnt;
  logic [5:0]  exp_sel;
  logic [7:0]  exp_seg;
  logic        exp_valid;

  int          n_pulse = 0;
  logic        mon_valid = 1'b0, mon_err = 1'b0;
  logic [5:0]  mon_sel = '0;
  logic [7:0]  mon_seg = '0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always @(negedge sys_clk) begin
    if (frame_valid || frame_err) begin
      n_pulse++;
      mon_valid = frame_valid;
      mon_err   = frame_err;
      mon_sel   = sel;
      mon_seg   = seg;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (14) hist.push_back(1'b0);
    since   = 0;
    exp_cnt = 16'h0000;
  endtask

  task automatic model_latch();
    int n;
    n = hist.size();
    for (int i = 0; i < 6; i++) exp_sel[i] = hist[n-14+i];
    for (int j = 0; j < 8; j++) exp_seg[7-j] = hist[n-8+j];
    exp_valid = (since == 14);
    if (exp_valid) exp_cnt = exp_cnt + 16'd1;
    since = 0;
  endtask

  task automatic send_bit(input logic b);
    ds = b;
    tick(2);
    shcp = 1'b1;
    hist.push_back(b);
    since++;
    tick(2);
    shcp = 1'b0;
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  task automatic send_frame(input logic [5:0] s, input logic [7:0] g);
    for (int i = 0; i < 6; i++) send_bit(s[i]);
    for (int j = 7; j >= 0; j--) send_bit(g[j]);
  endtask

  task automatic pulse_stcp();
    model_latch();
    stcp = 1'b1;
    tick(2);
    stcp = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    int p;
    sys_rst = 1'b1; ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ds = 1'($urandom); shcp = ~shcp; stcp = (i % 3) == 0;
      tick(1);
    end
    total++;
    if ({sel, seg, disp_en, frame_valid, frame_err, frame_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_vals: got sel=%b seg=%h en=%b v=%b e=%b cnt=%h want all 0",
               sel, seg, disp_en, frame_valid, frame_err, frame_cnt);
    end
    ds = 1'b1; shcp = 1'b1; stcp = 1'b1;
    tick(2);
    p = n_pulse;
    sys_rst = 1'b0;
    model_reset();
    tick(8);
    total++;
    if (n_pulse !== p) begin
      bad++;
      $display("FAIL reset_high_stcp: got %0d pulses want 0", n_pulse - p);
    end
    shcp = 1'b0; stcp = 1'b0; ds = 1'b0;
    tick(3);
    p = n_pulse;
    pulse_stcp();
    total++;
    if (n_pulse !== p + 1 || mon_err !== 1'b1 || mon_sel !== exp_sel || mon_seg !== exp_seg) begin
      bad++;
      $display("FAIL reset_first_latch: got n=%0d err=%b sel=%b seg=%h want n=%0d err=1 sel=%b seg=%h",
               n_pulse - p, mon_err, mon_sel, mon_seg, 1, exp_sel, exp_seg);
    end
  endtask

  task automatic test_full_frame();
    send_frame(6'b111110, 8'hC0);
    model_latch();
    stcp = 1'b1;
    tick(2);
    total++;
    if (frame_valid !== 1'b0 || sel !== 6'b0) begin
      bad++;
      $display("FAIL full_early: got v=%b sel=%b want v=0 sel=000000", frame_valid, sel);
    end
    tick(1);
    total++;
    if (frame_valid !== 1'b1 || frame_err !== 1'b0 || sel !== 6'b111110 || seg !== 8'hC0) begin
      bad++;
      $display("FAIL full_latch: got v=%b e=%b sel=%b seg=%h want v=1 e=0 sel=111110 seg=c0",
               frame_valid, frame_err, sel, seg);
    end
    tick(1);
    total++;
    if (frame_valid !== 1'b0 || frame_cnt !== exp_cnt || exp_cnt !== 16'd1) begin
      bad++;
      $display("FAIL full_pulse_cnt: got v=%b cnt=%0d want v=0 cnt=%0d", frame_valid, frame_cnt, exp_cnt);
    end
    stcp = 1'b0;
    tick(3);
  endtask

  task automatic test_short_frame();
    int p;
    send_rand(10);
    p = n_pulse;
    pulse_stcp();
    total++;
    if (n_pulse !== p + 1 || mon_err !== 1'b1 || mon_valid !== 1'b0 ||
        mon_sel !== exp_sel || mon_seg !== exp_seg || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL short: got n=%0d v=%b e=%b sel=%b seg=%h cnt=%0d want n=1 v=0 e=1 sel=%b seg=%h cnt=%0d",
               n_pulse - p, mon_valid, mon_err, mon_sel, mon_seg, frame_cnt, exp_sel, exp_seg, exp_cnt);
    end
  endtask

  task automatic test_over_shift();
    int p;
    send_rand(16);
    p = n_pulse;
    pulse_stcp();
    total++;
    if (n_pulse !== p + 1 || mon_err !== 1'b1 || mon_valid !== 1'b0 ||
        mon_sel !== exp_sel || mon_seg !== exp_seg || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL over: got n=%0d v=%b e=%b sel=%b seg=%h cnt=%0d want n=1 v=0 e=1 sel=%b seg=%h cnt=%0d",
               n_pulse - p, mon_valid, mon_err, mon_sel, mon_seg, frame_cnt, exp_sel, exp_seg, exp_cnt);
    end
  endtask

  task automatic test_simultaneous();
    int   p;
    logic b;
    send_rand(14);
    b = 1'($urandom);
    ds = b;
    tick(2);
    model_latch();
    hist.push_back(b);
    since = 1;
    p = n_pulse;
    shcp = 1'b1; stcp = 1'b1;
    tick(2);
    shcp = 1'b0; stcp = 1'b0;
    tick(3);
    total++;
    if (n_pulse !== p + 1 || mon_valid !== 1'b1 || mon_sel !== exp_sel || mon_seg !== exp_seg) begin
      bad++;
      $display("FAIL simul_latch: got n=%0d v=%b sel=%b seg=%h want n=1 v=1 sel=%b seg=%h",
               n_pulse - p, mon_valid, mon_sel, mon_seg, exp_sel, exp_seg);
    end
    send_rand(13);
    p = n_pulse;
    pulse_stcp();
    total++;
    if (n_pulse !== p + 1 || mon_valid !== 1'b1 || mon_sel !== exp_sel ||
        mon_seg !== exp_seg || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL simul_next: got n=%0d v=%b sel=%b seg=%h cnt=%0d want n=1 v=1 sel=%b seg=%h cnt=%0d",
               n_pulse - p, mon_valid, mon_sel, mon_seg, frame_cnt, exp_sel, exp_seg, exp_cnt);
    end
  endtask

  task automatic test_loopback();
    int         p;
    logic [5:0] s;
    for (int k = 0; k < 16; k++) begin
      s = 6'($urandom);
      send_frame(s, seg_tab[k]);
      p = n_pulse;
      pulse_stcp();
      total++;
      if (n_pulse !== p + 1 || mon_valid !== 1'b1 || mon_sel !== s ||
          mon_seg !== seg_tab[k] || frame_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL loop_%0d: got n=%0d v=%b sel=%b seg=%h cnt=%0d want n=1 v=1 sel=%b seg=%h cnt=%0d",
                 k, n_pulse - p, mon_valid, mon_sel, mon_seg, frame_cnt, s, seg_tab[k], exp_cnt);
      end
    end
  endtask

  task automatic test_oe();
    for (int k = 0; k < 6; k++) begin
      tick(1 + ($urandom % 3));
      oe = ~oe;
      tick(2);
      total++;
      if (disp_en !== oe) begin
        bad++;
        $display("FAIL oe_early_%0d: got disp_en=%b want %b", k, disp_en, oe);
      end
      tick(1);
      total++;
      if (disp_en !== ~oe) begin
        bad++;
        $display("FAIL oe_follow_%0d: got disp_en=%b want %b", k, disp_en, ~oe);
      end
    end
  endtask

  task automatic test_cnt_wrap();
    int p;
    force dut.frame_cnt = 16'hFFFF;
    tick(1);
    release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    send_frame(6'($urandom), 8'($urandom));
    p = n_pulse;
    pulse_stcp();
    total++;
    if (n_pulse !== p + 1 || mon_valid !== 1'b1 || frame_cnt !== exp_cnt || frame_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL cnt_wrap: got n=%0d v=%b cnt=%h want n=1 v=1 cnt=0000",
               n_pulse - p, mon_valid, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_over_shift();
    test_simultaneous();
    test_loopback();
    test_oe();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
